sum_accumulator: RTL and testbench



---
 rtl/sum_acc_pkg.sv | 13 +
 rtl/acc_step.sv | 28 ++
 rtl/sum_accumulator.sv | 109 ++++++++++
 tb/tb_sum_accumulator.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_acc_pkg.sv
// Shared types and widths for the sum_accumulator block and its datapath step.
// Optional build macro used by this block: SUM_ACC_SATURATE_EN.
package sum_acc_pkg;

  localparam int SUM_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage : sum_acc_pkg

// File: rtl/acc_step.sv
// One accumulate step: acc + zero-extended sum, with carry out of ACC_W.
// Build option: SUM_ACC_SATURATE_EN clamps the result to all-ones on carry instead of wrapping.
module acc_step
  import sum_acc_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [SUM_W-1:0] sum_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             carry_o
);

  logic [ACC_W:0] sum_full;

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    sum_full = {1'b0, acc_i} + {{(ACC_W + 1 - SUM_W){1'b0}}, sum_i};
    carry_o  = sum_full[ACC_W];
`ifdef SUM_ACC_SATURATE_EN
    // Once clamped, later adds carry again and re-clamp, so acc stays pinned until the frame ends.
    acc_o    = carry_o ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
    acc_o    = sum_full[ACC_W-1:0];
`endif
  end

endmodule : acc_step

// File: rtl/sum_accumulator.sv
// Accumulates N_SAMPLES adder sums into one frame total and presents it over a valid/ready port.
// Build option: SUM_ACC_SATURATE_EN (handled inside acc_step) selects saturating instead of wrapping adds.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int ACC_W     = 8,
  parameter int N_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_total_q, out_total_d;
  logic               out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0]   step_acc;
  logic               step_carry;
  logic               beat;

  acc_step #(
    .ACC_W (ACC_W)
  ) u_acc_step (
    .acc_i   (acc_q),
    .sum_i   (in_sum),
    .acc_o   (step_acc),
    .carry_o (step_carry)
  );

  // Ready depends only on state and reset, never on in_valid.
  assign in_ready = (state_q == ACCUM) && !rst;
  assign beat     = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_total_d = out_total_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      ACCUM: begin
        if (beat) begin
          if (cnt_q == LAST_CNT) begin
            out_total_d = step_acc;
            out_ovf_d   = ovf_q | step_carry;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = HOLD;
          end else begin
            acc_d = step_acc;
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | step_carry;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_total_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_total_q <= out_total_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_total = out_total_q;
  assign out_ovf   = out_ovf_q;

endmodule : sum_accumulator

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: an 8-bit/4-sample instance and a 5-bit/3-sample overflow instance.
module tb_sum_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
  logic [3:0] a_in_sum;
  logic [7:0] a_out_total;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [3:0] b_in_sum;
  logic [4:0] b_out_total;

  sum_accumulator #(.ACC_W(8), .N_SAMPLES(4)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_sum    (a_in_sum),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_total (a_out_total),
    .out_ovf   (a_out_ovf)
  );

  sum_accumulator #(.ACC_W(5), .N_SAMPLES(3)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_sum    (b_in_sum),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_total (b_out_total),
    .out_ovf   (b_out_ovf)
  );

`ifdef SUM_ACC_SATURATE_EN
  localparam logic [15:0] B_OVF_TOTAL = 16'd31;
`else
  localparam logic [15:0] B_OVF_TOTAL = 16'd13;
`endif

  typedef struct {
    logic [15:0] sums;      // four nibbles, first beat in [15:12]
    int          gap;       // idle cycles after each non-final beat
    logic [15:0] exp_total;
    logic        exp_ovf;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries are {ovf, total}.
  logic [16:0] exp_a[$];
  logic [16:0] obs_a[$];
  logic [16:0] exp_b[$];
  logic [16:0] obs_b[$];

  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) obs_a.push_back({a_out_ovf, 8'h00, a_out_total});
    if (b_out_valid && b_out_ready) obs_b.push_back({b_out_ovf, 11'h000, b_out_total});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Entered and left at posedge+1; the beat is accepted at the edge where in_ready was high beforehand.
  task automatic send_a(input logic [3:0] s);
    logic rdy;
    bit   done = 0;
    a_in_valid = 1'b1;
    a_in_sum   = s;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      rdy = a_in_ready;
      @(posedge clk);
      #1;
      done = rdy;
    end
    a_in_valid = 1'b0;
    if (!done) timeout("send_a");
  endtask

  task automatic send_b(input logic [3:0] s);
    logic rdy;
    bit   done = 0;
    b_in_valid = 1'b1;
    b_in_sum   = s;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      rdy = b_in_ready;
      @(posedge clk);
      #1;
      done = rdy;
    end
    b_in_valid = 1'b0;
    if (!done) timeout("send_b");
  endtask

  task automatic expect_frame_a(input string name);
    logic [16:0] e, o;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (obs_a.size() != 0) break;
    end
    if (obs_a.size() == 0) timeout(name);
    else if (exp_a.size() == 0) begin
      void'(obs_a.pop_front());
      timeout({name, " unexpected frame"});
    end else begin
      e = exp_a.pop_front();
      o = obs_a.pop_front();
      check({name, " total"}, 32'(o[15:0]), 32'(e[15:0]));
      check({name, " ovf"}, 32'(o[16]), 32'(e[16]));
    end
  endtask

  task automatic expect_frame_b(input string name);
    logic [16:0] e, o;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (obs_b.size() != 0) break;
    end
    if (obs_b.size() == 0 || exp_b.size() == 0) timeout(name);
    else begin
      e = exp_b.pop_front();
      o = obs_b.pop_front();
      check({name, " total"}, 32'(o[15:0]), 32'(e[15:0]));
      check({name, " ovf"}, 32'(o[16]), 32'(e[16]));
    end
  endtask

  initial begin
    vec_t        vecs[4];
    logic [15:0] packed_sums;

    vecs[0] = '{sums: 16'h5073, gap: 2, exp_total: 16'd15, exp_ovf: 1'b0};
    vecs[1] = '{sums: 16'hFEDC, gap: 0, exp_total: 16'd54, exp_ovf: 1'b0};
    vecs[2] = '{sums: 16'h0000, gap: 1, exp_total: 16'd0,  exp_ovf: 1'b0};
    vecs[3] = '{sums: 16'h8169, gap: 0, exp_total: 16'd24, exp_ovf: 1'b0};

    rst         = 1'b1;
    a_in_valid  = 1'b0;
    a_in_sum    = 4'd0;
    a_out_ready = 1'b1;
    b_in_valid  = 1'b0;
    b_in_sum    = 4'd0;
    b_out_ready = 1'b1;

    // Reset behaviour.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst a_in_ready", 32'(a_in_ready), 0);
      check("rst b_in_ready", 32'(b_in_ready), 0);
      check("rst out_valid", 32'(a_out_valid), 0);
      check("rst out_total", 32'(a_out_total), 0);
      check("rst out_ovf", 32'(a_out_ovf), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post-rst a_in_ready", 32'(a_in_ready), 1);
    check("post-rst b_in_ready", 32'(b_in_ready), 1);
    check("post-rst out_valid", 32'(a_out_valid), 0);
    @(posedge clk);
    #1;

    // Basic frame on consecutive cycles, with latency and ready checks.
    exp_a.push_back({1'b0, 16'd10});
    send_a(4'd1);
    send_a(4'd2);
    send_a(4'd3);
    send_a(4'd4);
    @(negedge clk);
    check("basic out_valid", 32'(a_out_valid), 1);
    check("basic in_ready hs", 32'(a_in_ready), 0);
    check("basic out_total", 32'(a_out_total), 10);
    @(negedge clk);
    check("basic in_ready resume", 32'(a_in_ready), 1);
    check("basic out_valid drop", 32'(a_out_valid), 0);
    expect_frame_a("basic");

    // Table-driven frames, some with idle gaps between beats.
    foreach (vecs[v]) begin
      packed_sums = vecs[v].sums;
      exp_a.push_back({vecs[v].exp_ovf, vecs[v].exp_total});
      for (int j = 0; j < 4; j++) begin
        send_a(packed_sums[15 - 4*j -: 4]);
        if (j < 3) begin
          for (int g = 0; g < vecs[v].gap; g++) begin
            @(negedge clk);
            check($sformatf("vec%0d no early frame", v), 32'(a_out_valid), 0);
            @(posedge clk);
            #1;
          end
        end
      end
      @(negedge clk);
      check($sformatf("vec%0d latency", v), 32'(a_out_valid), 1);
      expect_frame_a($sformatf("vec%0d", v));
    end

    // Backpressure: result held while the sink stalls, pending beat waits.
    a_out_ready = 1'b0;
    exp_a.push_back({1'b0, 16'd60});
    for (int j = 0; j < 4; j++) send_a(4'd15);
    a_in_valid = 1'b1;
    a_in_sum   = 4'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp out_valid", 32'(a_out_valid), 1);
      check("bp out_total", 32'(a_out_total), 60);
      check("bp in_ready", 32'(a_in_ready), 0);
    end
    @(posedge clk);
    #1;
    a_out_ready = 1'b1;
    @(negedge clk);
    check("bp hs in_ready", 32'(a_in_ready), 0);
    check("bp hs out_valid", 32'(a_out_valid), 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp resume in_ready", 32'(a_in_ready), 1);
    check("bp resume out_valid", 32'(a_out_valid), 0);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    expect_frame_a("bp");
    exp_a.push_back({1'b0, 16'd10});
    send_a(4'd3);
    send_a(4'd4);
    send_a(4'd1);
    expect_frame_a("bp next");

    // Overflow on the narrow instance, then a clean frame to show the flag cleared.
    exp_b.push_back({1'b1, B_OVF_TOTAL});
    for (int j = 0; j < 3; j++) send_b(4'd15);
    expect_frame_b("ovf");
    exp_b.push_back({1'b0, 16'd6});
    send_b(4'd1);
    send_b(4'd2);
    send_b(4'd3);
    expect_frame_b("ovf clear");

    // Reset mid-frame discards the partial beats.
    send_a(4'd9);
    send_a(4'd9);
    rst = 1'b1;
    @(negedge clk);
    check("midrst in_ready", 32'(a_in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst out_valid", 32'(a_out_valid), 0);
    check("midrst in_ready after", 32'(a_in_ready), 1);
    @(posedge clk);
    #1;
    exp_a.push_back({1'b0, 16'd4});
    for (int j = 0; j < 4; j++) send_a(4'd1);
    expect_frame_a("midrst");

    repeat (4) @(posedge clk);
    #1;
    check("a leftover frames", 32'(obs_a.size()), 0);
    check("b leftover frames", 32'(obs_b.size()), 0);
    check("a missing frames", 32'(exp_a.size()), 0);
    check("b missing frames", 32'(exp_b.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sum_accumulator
